// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-access stage: size encodings, FSM states,
// read-latency counter width and small address helpers.
package mem_access_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Wide enough for READ_LAT up to 3.
  localparam int unsigned LAT_CNT_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWr,
    StResp
  } state_e;

  // Reserved encoding 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_W : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
  endfunction

  // Clears the low address bits that a naturally aligned access of this size ignores.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] res;
    case (size)
      SIZE_B:  res = lo;
      SIZE_H:  res = {lo[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane logic: little-endian load extract/extend and store merge
// of a sub-word into a full memory word.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'b00:   byte_sel = word_i[7:0];
      2'b01:   byte_sel = word_i[15:8];
      2'b10:   byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_data_o = word_i;
    case (size_i)
      SIZE_B:  load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SIZE_H:  load_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    store_word_o = word_i;
    case (size_i)
      SIZE_B: begin
        case (addr_i)
          2'b00:   store_word_o[7:0]   = wdata_i[7:0];
          2'b01:   store_word_o[15:8]  = wdata_i[7:0];
          2'b10:   store_word_o[23:16] = wdata_i[7:0];
          default: store_word_o[31:24] = wdata_i[7:0];
        endcase
      end
      SIZE_H: begin
        if (addr_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else           store_word_o[15:0]  = wdata_i[15:0];
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: load/store to a word-wide memory, read-modify-write for sub-word stores.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [LAT_CNT_W-1:0] LastCnt = LAT_CNT_W'(READ_LAT - 1);

  state_e                state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            lo_q, lo_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           mem_address_q, mem_address_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;

  logic [1:0]            req_size_n;
  logic                  trap;
  logic [31:0]           load_data;
  logic [31:0]           store_word;

  assign req_size_n = norm_size(req_size);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size_n, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lane_align u_lane_align (
    .word_i       (mem_read_data),
    .addr_i       (lo_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lo_d          = lo_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    resp_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size_n;
          uns_d   = req_unsigned;
          lo_d    = align_lo(req_size_n, req_addr[1:0]);
          wdata_d = req_wdata;
          if (trap) begin
            // No memory access at all; mem_address keeps its previous value.
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_size_n == SIZE_W)) begin
            state_d       = StWr;
            mem_address_d = {2'b00, req_addr[31:2]};
            mem_we_d      = 1'b1;
            mem_wdata_d   = req_wdata;
          end else begin
            state_d       = StRdWait;
            mem_address_d = {2'b00, req_addr[31:2]};
            cnt_d         = '0;
          end
        end
      end
      StRdWait: begin
        if (cnt_q == LastCnt) begin
          if (we_q) begin
            state_d     = StWr;
            mem_we_d    = 1'b1;
            mem_wdata_d = store_word;
          end else begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + LAT_CNT_W'(1);
        end
      end
      StWr: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      size_q        <= SIZE_W;
      uns_q         <= 1'b0;
      lo_q          <= 2'b00;
      wdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lo_q          <= lo_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign req_ready        = (state_q == StIdle);
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_err         = resp_err_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random loads/stores against a
// byte-level reference model; a second instance checks READ_LAT=3 timing.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic        r3_valid = 1'b0;
  logic        r3_ready;
  logic [31:0] r3_addr = '0;
  logic        r3_resp_valid;
  logic [31:0] r3_resp_rdata;
  logic        r3_resp_err;
  logic [31:0] r3_mem_address;
  logic [31:0] r3_mem_write_data;
  logic        r3_mem_write_enable;
  logic [31:0] r3_mem_read_data;

  // Test memory (environment) and reference image (model).
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_LAT(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  mem_access_unit #(.READ_LAT(3)) dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (r3_valid),
    .req_ready        (r3_ready),
    .req_we           (1'b0),
    .req_size         (2'b10),
    .req_unsigned     (1'b0),
    .req_addr         (r3_addr),
    .req_wdata        (32'h0),
    .resp_valid       (r3_resp_valid),
    .resp_rdata       (r3_resp_rdata),
    .resp_err         (r3_resp_err),
    .mem_address      (r3_mem_address),
    .mem_write_data   (r3_mem_write_data),
    .mem_write_enable (r3_mem_write_enable),
    .mem_read_data    (r3_mem_read_data)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
  end

  assign mem_read_data    = mem[mem_address[7:0]];
  assign r3_mem_read_data = mem[r3_mem_address[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[int'(lo) * 8 +: 8];
    h = w[(lo[1] ? 16 : 0) +: 16];
    if (sz == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  // Drives one request and records when WE and the response appear, relative to accept cycle k.
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [1:0]  sz;
    logic        trap;
    int          idx, exp_lat, exp_we_at, cyc, resp_at, we_at, we_cnt;
    logic [31:0] exp_rd;
    sz      = (size == 2'b11) ? 2'b10 : size;
    idx     = int'(addr[9:2]);
    trap    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = ((sz == 2'b01) && addr[0]) || ((sz == 2'b10) && (addr[1:0] != 2'b00));
`endif
    exp_rd = '0;
    if (trap) begin
      exp_lat = 1; exp_we_at = -1;
    end else if (!we) begin
      exp_lat = 2; exp_we_at = -1; exp_rd = model_load(ref_mem[idx], addr[1:0], sz, uns);
    end else if (sz == 2'b10) begin
      exp_lat = 2; exp_we_at = 1;
    end else begin
      exp_lat = 3; exp_we_at = 2;
    end

    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    cyc = 1; resp_at = -1; we_at = -1; we_cnt = 0;
    if (!trap) check("mem_address", mem_address, {2'b00, addr[31:2]});
    while (cyc <= 10 && resp_at < 0) begin
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      if (mem_write_enable) begin we_cnt++; we_at = cyc; end
      if (resp_valid) begin
        resp_at = cyc;
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", {31'd0, resp_err}, {31'd0, trap});
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("resp_latency", resp_at, exp_lat);
    check("we_cycle", we_at, exp_we_at);
    check("we_count", we_cnt, (exp_we_at > 0) ? 1 : 0);

    if (we && !trap) begin
      if (sz == 2'b00)      ref_mem[idx][int'(addr[1:0]) * 8 +: 8] = wdata[7:0];
      else if (sz == 2'b01) ref_mem[idx][(addr[1] ? 16 : 0) +: 16] = wdata[15:0];
      else                  ref_mem[idx] = wdata;
    end
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int cyc, resp_at;
    // Preload memory while both DUTs are held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = 8'(i);
      pre_data = (i == 8'h77) ? 32'h11223344 : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);

    // Directed scenarios.
    do_op(1'b1, 2'b10, 1'b0, 32'h198, 32'hDEADBEEF);
    do_op(1'b0, 2'b10, 1'b0, 32'h198, 32'h0);
    do_op(1'b1, 2'b00, 1'b0, 32'h1DD, 32'h000000AB);
    check("byte_merge", mem[8'h77], 32'h1122AB44);
    do_op(1'b0, 2'b00, 1'b0, 32'h1DD, 32'h0);
    do_op(1'b0, 2'b01, 1'b1, 32'h1DE, 32'h0);
    do_op(1'b0, 2'b10, 1'b0, 32'h155, 32'h0);
    do_op(1'b1, 2'b01, 1'b0, 32'h1DF, 32'h0000BEEF);
    do_op(1'b0, 2'b11, 1'b0, 32'h1DC, 32'h0);

    // Random mix of all sizes, signedness and alignments.
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 32'($urandom_range(0, 1023)),
            $urandom);
    end

    // Reset asserted during RD_WAIT of a byte store aborts it with no write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h1E1; req_wdata = 32'h000000CD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_rdwait_we", {31'd0, mem_write_enable}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_resp_err", {31'd0, resp_err}, 32'd0);
    check("abort_mem_address", mem_address, 32'd0);
    check("abort_mem_wdata", mem_write_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_we", {31'd0, mem_write_enable}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_we_after", {31'd0, mem_write_enable}, 32'd0);
    check("abort_mem", mem[8'h78], ref_mem[8'h78]);
    do_op(1'b0, 2'b00, 1'b1, 32'h1E1, 32'h0);

    // READ_LAT=3 instance: response exactly 4 cycles after accept.
    @(negedge clk);
    check("lat3_ready_idle", {31'd0, r3_ready}, 32'd1);
    r3_valid = 1'b1; r3_addr = 32'h04;
    @(posedge clk); #1;
    r3_valid = 1'b0;
    cyc = 1; resp_at = -1;
    while (cyc <= 10 && resp_at < 0) begin
      check("lat3_ready_busy", {31'd0, r3_ready}, 32'd0);
      if (r3_resp_valid) begin
        resp_at = cyc;
        check("lat3_rdata", r3_resp_rdata, ref_mem[1]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("lat3_latency", resp_at, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the execution cycle: accepts load/store requests from the execute stage, drives the word-wide `memory` block (word address, write data, write enable), and returns aligned, extended load data to writeback. Byte and halfword stores are performed as read-modify-write sequences, because `memory` has no byte enables. Sits directly upstream of `memory`, between execute and writeback.

## Interface
Parameters:
- `READ_LAT`, 1: cycles from a stable `mem_address` to valid `mem_read_data` (1–3).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `req_unsigned`  in  1  zero-extend load result
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, LSB-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores
- `resp_err`  out  1  misaligned access (see Configuration)
- `mem_address`  out  32  word index = {2'b00, req_addr[31:2]}
- `mem_write_data`  out  32  word to write
- `mem_write_enable`  out  1  write strobe to `memory`
- `mem_read_data`  in  32  read word from `memory`

Single clock `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- FSM states: IDLE, RD_WAIT, WR, RESP.
- IDLE: `req_ready`=1. A handshake (`req_valid` && `req_ready`) latches all `req_*` fields.
- IDLE transitions after a handshake:
  - Load or sub-word store: go to RD_WAIT.
  - Word store: go to WR.
  - Misaligned access with the macro defined: go to RESP.
- RD_WAIT: `mem_address` is held. A counter runs `READ_LAT` cycles, then `mem_read_data` is captured.
  - Load: go to RESP.
  - Sub-word store: go to WR.
- WR: `mem_write_enable`=1 for exactly one cycle.
  - Word store: `mem_write_data` = `req_wdata`.
  - Byte store: the captured word with lane `addr[1:0]` replaced by `wdata[7:0]`.
  - Half store: the captured word with lane `addr[1]` replaced by `wdata[15:0]`.
  - Then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- Load extract: little-endian. Byte lane is `addr[1:0]`, half lane is `addr[1]`. Sign-extend unless `req_unsigned`.
- `req_ready`=0 in every state except IDLE. There is no response backpressure.

## Timing
- Accept in cycle k; `READ_LAT`=1 in all cycle numbers below.
  - Load: `resp_valid` in cycle k+2 (generally k+READ_LAT+1).
  - Word store: WE in cycle k+1, `resp_valid` in k+2.
  - Sub-word store: read in k+1, WE in k+2, `resp_valid` in k+3.
- Outputs are registered: `mem_*`, `resp_*`.
- Reset values: state IDLE; `req_ready`=1 once reset is released. All other outputs are 0: `resp_valid`, `resp_rdata`, `resp_err`, `mem_address`, `mem_write_data`, `mem_write_enable`.
- Reset mid-operation aborts the access immediately. If the reset lands before the WR cycle, no write is issued, and the memory contents are unchanged.
- `req_*` inputs are ignored outside IDLE. Back-to-back requests are spaced by at least one IDLE cycle.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A half with `addr[0]`=1, or a word with `addr[1:0]`≠0, makes no memory access.
  - RESP follows in cycle k+1 with `resp_err`=1 and `resp_rdata`=0.
- Undefined:
  - The offending low address bits are forced to 0 (natural alignment).
  - `resp_err` is tied to 0.

## Structure
- Package `mem_access_pkg` holds:
  - the size encodings SIZE_B / SIZE_H / SIZE_W;
  - the FSM state enum;
  - the `READ_LAT` counter width constant.
- Sub-module `lane_align` is purely combinational. It does load extract/extend and store merge from (word, addr[1:0], size, unsigned, wdata).

## Test plan
- Word store 0xDEADBEEF @0x198, then word load @0x198 → `mem_address`=0x66, WE pulse in k+1, load `resp_rdata`=0xDEADBEEF in k+2.
- Memory word 0x11223344 @0x1DC; byte store 0xAB @0x1DD → word becomes 0x1122AB44, with exactly one WE cycle at k+2.
- Load from that word, signed byte @0x1DD → 0xFFFFFFAB. Unsigned half @0x1DE → 0x00001122.
- Word load @0x155 with the macro defined → `resp_err`=1, `resp_rdata`=0, no WE, response in k+1. Without the macro → reads word 0x55, `resp_err`=0.
- Assert `rst_n` low during RD_WAIT of a byte store → no WE observed, memory unchanged, all outputs 0, IDLE on release.
- `READ_LAT`=3, load @0x04 → `resp_valid` exactly 4 cycles after accept. `req_ready`=0 throughout.
